// File: rtl/tone_alarm_gen.sv
// Alarm-tone generator for the PmodAMP2 path: continuous tone, counted beep cadence, or two-tone siren.
// Optional feature macro: TONE_SIREN_EN (defined: mode 2 alternates tone A/B; undefined: mode 2 acts as mode 0).
module tone_alarm_gen #(
    parameter int unsigned HALF_A     = 113636,
    parameter int unsigned HALF_B     = 75843,
    parameter int unsigned DIV_W      = 17,
    parameter int unsigned CAD_CYCLES = 25000000,
    parameter int unsigned CAD_W      = 25,
    parameter int unsigned BEEP_COUNT = 3,
    parameter bit          GAIN_HI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buzzer_on,
    input  logic       NoBuzz,
    input  logic [1:0] mode,
    output logic       audio_out,
    output logic       amp_gain,
    output logic       amp_shdn,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_e;

    localparam int unsigned BC_W = $clog2(BEEP_COUNT + 1);

    localparam logic [DIV_W-1:0] A_LAST    = DIV_W'(HALF_A - 1);
    localparam logic [CAD_W-1:0] CAD_LAST  = CAD_W'(CAD_CYCLES - 1);
    localparam logic [BC_W-1:0]  BEEP_LAST = BC_W'(BEEP_COUNT);

    if (HALF_A < 2 || HALF_B < 2 || CAD_CYCLES < 1 || BEEP_COUNT < 1) begin : g_param_check
        $error("tone_alarm_gen: illegal parameter value");
    end

    state_e           state_q, state_d;
    logic             buz_prev_q;
    logic             armed_q;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [CAD_W-1:0] cad_cnt_q, cad_cnt_d;
    logic [BC_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic             spk_q, spk_d;
    logic             done_q, done_d;
    logic             shdn_q, shdn_d;
    logic [DIV_W-1:0] half_last;
    logic             cad_wrap;
    logic             start;
    logic             is_beep;
    logic             tone_clr;

`ifdef TONE_SIREN_EN
    localparam logic [DIV_W-1:0] B_LAST = DIV_W'(HALF_B - 1);
    logic tone_sel_q, tone_sel_d;
    logic is_siren;

    assign is_siren  = (mode_q == 2'd2);
    assign half_last = tone_sel_q ? B_LAST : A_LAST;
`else
    assign half_last = A_LAST;
`endif

    // A level that is already high when reset releases must not start a run,
    // so starts are only armed once buzzer_on has been seen low.
    assign start    = buzzer_on && !buz_prev_q && armed_q;
    assign cad_wrap = (cad_cnt_q == CAD_LAST);
    assign is_beep  = (mode_q == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            buz_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            mode_q     <= 2'd0;
            tone_cnt_q <= '0;
            cad_cnt_q  <= '0;
            beep_cnt_q <= '0;
            spk_q      <= 1'b0;
            done_q     <= 1'b0;
            shdn_q     <= 1'b0;
`ifdef TONE_SIREN_EN
            tone_sel_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buz_prev_q <= buzzer_on;
            armed_q    <= armed_q | ~buzzer_on;
            mode_q     <= mode_d;
            tone_cnt_q <= tone_cnt_d;
            cad_cnt_q  <= cad_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            spk_q      <= spk_d;
            done_q     <= done_d;
            shdn_q     <= shdn_d;
`ifdef TONE_SIREN_EN
            tone_sel_q <= tone_sel_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cad_cnt_d  = cad_cnt_q;
        beep_cnt_d = beep_cnt_q;
        done_d     = 1'b0;
        tone_clr   = 1'b0;
`ifdef TONE_SIREN_EN
        tone_sel_d = tone_sel_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ON;
                    mode_d     = mode;
                    cad_cnt_d  = '0;
                    beep_cnt_d = '0;
`ifdef TONE_SIREN_EN
                    tone_sel_d = 1'b0;
`endif
                end
            end
            S_ON: begin
                if (!buzzer_on) begin
                    state_d = S_IDLE;
                end else begin
                    cad_cnt_d = cad_wrap ? '0 : cad_cnt_q + 1'b1;
                    if (cad_wrap && is_beep) begin
                        state_d    = S_OFF;
                        beep_cnt_d = beep_cnt_q + 1'b1;
                    end
`ifdef TONE_SIREN_EN
                    if (cad_wrap && is_siren) begin
                        tone_sel_d = ~tone_sel_q;
                        tone_clr   = 1'b1;
                    end
`endif
                end
            end
            S_OFF: begin
                if (!buzzer_on) begin
                    state_d = S_IDLE;
                end else begin
                    cad_cnt_d = cad_wrap ? '0 : cad_cnt_q + 1'b1;
                    if (cad_wrap) begin
                        if (beep_cnt_q < BEEP_LAST) begin
                            state_d = S_ON;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Tone runs only while staying in ON unmuted; anything else restarts it from phase 0.
        if (state_q == S_ON && state_d == S_ON && !NoBuzz && !tone_clr) begin
            if (tone_cnt_q == half_last) begin
                tone_cnt_d = '0;
                spk_d      = ~spk_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
                spk_d      = spk_q;
            end
        end else begin
            tone_cnt_d = '0;
            spk_d      = 1'b0;
        end

        shdn_d = (state_d != S_IDLE) && !NoBuzz;
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        audio_out = spk_q;
        amp_shdn  = shdn_q;
        done      = done_q;
        amp_gain  = GAIN_HI;
    end

endmodule

// File: tb/tb_tone_alarm_gen.sv
// Directed bench for tone_alarm_gen with HALF_A=4, HALF_B=6, CAD_CYCLES=20, BEEP_COUNT=2.
module tb_tone_alarm_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       buzzer_on;
    logic       NoBuzz;
    logic [1:0] mode;
    logic       audio_out;
    logic       amp_gain;
    logic       amp_shdn;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    tone_alarm_gen #(
        .HALF_A    (4),
        .HALF_B    (6),
        .DIV_W     (3),
        .CAD_CYCLES(20),
        .CAD_W     (5),
        .BEEP_COUNT(2),
        .GAIN_HI   (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .buzzer_on(buzzer_on),
        .NoBuzz   (NoBuzz),
        .mode     (mode),
        .audio_out(audio_out),
        .amp_gain (amp_gain),
        .amp_shdn (amp_shdn),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Leaves buzzer_on high so the next tick() is the ON-entry edge (cycle 0).
    task automatic start_run(input logic [1:0] m);
        buzzer_on = 1'b0;
        mode      = m;
        tick();
        tick();
        buzzer_on = 1'b1;
    endtask

    // Mode-1 audio after the edge i cycles past ON entry: ON bursts at [0,20) and [40,60).
    function automatic logic m1_audio(input int i);
        if (i < 80 && (i % 40) < 20) return (((i % 40) / 4) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic siren_audio(input int i);
`ifdef TONE_SIREN_EN
        if ((i % 40) >= 20) return ((((i % 40) - 20) / 6) % 2) == 1;
        return (((i % 40) / 4) % 2) == 1;
`else
        return ((i / 4) % 2) == 1;
`endif
    endfunction

    initial begin
        rst_n     = 1'b0;
        buzzer_on = 1'b1;
        NoBuzz    = 1'b0;
        mode      = 2'd0;

        // Reset held with buzzer_on high
        tick();
        tick();
        tick();
        chk("rst_audio", audio_out, 1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_shdn",  amp_shdn,  1'b0);
        chk("rst_gain",  amp_gain,  1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_start_high_level", busy, 1'b0);
        end

        // Mode 0: continuous tone, period 8
        start_run(2'd0);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("m0_audio", audio_out, ((i / 4) % 2) == 1);
            chk("m0_busy",  busy,      1'b1);
            chk("m0_shdn",  amp_shdn,  1'b1);
        end
        buzzer_on = 1'b0;
        tick();
        chk("m0_stop_audio", audio_out, 1'b0);
        chk("m0_stop_busy",  busy,      1'b0);
        chk("m0_stop_shdn",  amp_shdn,  1'b0);
        chk("m0_stop_done",  done,      1'b0);

        // Mode 1: two beeps, done at cycle 80; mode change mid-run must be ignored
        start_run(2'd1);
        for (int i = 0; i < 82; i++) begin
            tick();
            chk("m1_audio", audio_out, m1_audio(i));
            chk("m1_busy",  busy,      i < 80);
            chk("m1_done",  done,      i == 80);
            if (i == 2) mode = 2'd0;
        end

        // Mode 2: siren (or plain tone A without the siren feature)
        start_run(2'd2);
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("m2_audio", audio_out, siren_audio(i));
        end

        // Mode 1 muted over cycles 5..50
        start_run(2'd1);
        for (int i = 0; i < 82; i++) begin
            logic ea;
            tick();
            if (i >= 5 && i <= 50)      ea = 1'b0;
            else if (i > 50 && i < 60)  ea = (((i - 50) / 4) % 2) == 1;
            else                        ea = m1_audio(i);
            chk("mute_audio", audio_out, ea);
            chk("mute_shdn",  amp_shdn,  (i >= 5 && i <= 50) ? 1'b0 : (i < 80));
            chk("mute_done",  done,      i == 80);
            if (i == 4)  NoBuzz = 1'b1;
            if (i == 50) NoBuzz = 1'b0;
        end

        // Mode 1 aborted at cycle 30
        start_run(2'd1);
        for (int i = 0; i <= 30; i++) begin
            tick();
            chk("abort_busy_run", busy, 1'b1);
        end
        buzzer_on = 1'b0;
        tick();
        chk("abort_busy",  busy,      1'b0);
        chk("abort_shdn",  amp_shdn,  1'b0);
        chk("abort_audio", audio_out, 1'b0);
        for (int i = 0; i < 60; i++) begin
            chk("abort_no_done", done, 1'b0);
            tick();
        end

        // Asynchronous reset in the middle of ON
        start_run(2'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("pre_arst_audio", audio_out, 1'b1);
        chk("pre_arst_busy",  busy,      1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_audio", audio_out, 1'b0);
        chk("arst_busy",  busy,      1'b0);
        chk("arst_shdn",  amp_shdn,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
